// File: rtl/window_serializer_pkg.sv
// Shared constants, state encoding and window layout helper for the window
// serializer and its sibling window buffer.
package window_serializer_pkg;

  localparam int FILTER_SIZE    = 5;
  localparam int WIN_PIXELS     = FILTER_SIZE * FILTER_SIZE;
  localparam int DATA_BIT_WIDTH = 12;

  localparam logic [2:0] ROW_LAST = 3'd4;
  localparam logic [2:0] COL_LAST = 3'd4;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_e;

  // LSB position of pixel (row,col) inside the flattened row-major window.
  function automatic int pix_lsb(input int row, input int col, input int width);
    return row * FILTER_SIZE * width + col * width;
  endfunction

endpackage

// File: rtl/window_serializer_if.sv
// Window-in / pixel-out handshake bundle. The serializer takes the slave view,
// the producer/consumer side takes the master view.
interface window_serializer_if #(
  parameter int DataBitWidth = window_serializer_pkg::DATA_BIT_WIDTH
) ();

  logic                                                   win_valid;
  logic                                                   win_ready;
  logic [DataBitWidth*window_serializer_pkg::WIN_PIXELS-1:0] win_data;
  logic                                                   px_valid;
  logic                                                   px_ready;
  logic signed [DataBitWidth-1:0]                         px_data;
  logic                                                   px_first;
  logic                                                   px_last;
  logic [2:0]                                             px_row;
  logic [2:0]                                             px_col;

  modport slave (
    input  win_valid, win_data, px_ready,
    output win_ready, px_valid, px_data, px_first, px_last, px_row, px_col
  );

  modport master (
    output win_valid, win_data, px_ready,
    input  win_ready, px_valid, px_data, px_first, px_last, px_row, px_col
  );

endinterface

// File: rtl/window_pixel_mux.sv
// Combinational 25:1 pixel select of a flattened window by {row,col}.
module window_pixel_mux
  import window_serializer_pkg::*;
#(
  parameter int DataBitWidth = DATA_BIT_WIDTH
) (
  input  logic [DataBitWidth*WIN_PIXELS-1:0] win,
  input  logic [2:0]                         row,
  input  logic [2:0]                         col,
  output logic [DataBitWidth-1:0]            px
);

  always_comb begin
    // NOTE: assigning a default before any conditional write keeps this block
    // purely combinational; without it an unmatched {row,col} would infer a latch.
    px = '0;
    for (int r = 0; r < FILTER_SIZE; r++) begin
      for (int c = 0; c < FILTER_SIZE; c++) begin
        if (row == 3'(r) && col == 3'(c)) begin
          px = win[pix_lsb(r, c, DataBitWidth) +: DataBitWidth];
        end
      end
    end
  end

endmodule

// File: rtl/window_serializer.sv
// Parallel 5x5 window in, row-major serial pixel stream out. One active and one
// pending window give bubble-free back-to-back streaming.
module window_serializer
  import window_serializer_pkg::*;
#(
  parameter int DataBitWidth = DATA_BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  window_serializer_if.slave   bus
);

  localparam int WinBits = DataBitWidth * WIN_PIXELS;

  state_e                  state_q, state_d;
  logic [WinBits-1:0]      cur_q, cur_d;
  logic [WinBits-1:0]      pend_q, pend_d;
  logic                    pend_full_q, pend_full_d;
  logic [2:0]              row_q, row_d;
  logic [2:0]              col_q, col_d;
  logic                    px_valid_q, px_valid_d;
  logic [DataBitWidth-1:0] px_data_q, px_data_d;
  logic                    px_first_q, px_first_d;
  logic                    px_last_q, px_last_d;
  logic [DataBitWidth-1:0] mux_px;

  logic accept, beat, end_of_win;

  // accept and beat both carry en, so en=0 freezes every state element below.
  assign bus.win_ready = en & ~pend_full_q;
  assign accept        = bus.win_valid & bus.win_ready;
  assign beat          = px_valid_q & bus.px_ready & en;
  assign end_of_win    = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    row_d       = row_q;
    col_d       = col_q;
    px_valid_d  = px_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cur_d      = bus.win_data;
          row_d      = '0;
          col_d      = '0;
          px_valid_d = 1'b1;
          state_d    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (beat && end_of_win) begin
          row_d = '0;
          col_d = '0;
          if (pend_full_q) begin
            cur_d       = pend_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            cur_d = bus.win_data;
          end else begin
            px_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end else begin
          if (beat) begin
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + 3'd1;
            end else begin
              col_d = col_q + 3'd1;
            end
          end
          if (accept) begin
            pend_d      = bus.win_data;
            pend_full_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers are fed from the next-cycle window/position so the first
  // beat is visible one cycle after accept; when idle they hold their last value.
  window_pixel_mux #(.DataBitWidth(DataBitWidth)) u_pixel_mux (
    .win (cur_d),
    .row (row_d),
    .col (col_d),
    .px  (mux_px)
  );

  assign px_data_d  = px_valid_d ? mux_px : px_data_q;
  assign px_first_d = px_valid_d && (row_d == 3'd0) && (col_d == 3'd0);
  assign px_last_d  = px_valid_d && (row_d == ROW_LAST) && (col_d == COL_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_full_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      px_valid_q  <= 1'b0;
      px_data_q   <= '0;
      px_first_q  <= 1'b0;
      px_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      row_q       <= row_d;
      col_q       <= col_d;
      px_valid_q  <= px_valid_d;
      px_data_q   <= px_data_d;
      px_first_q  <= px_first_d;
      px_last_q   <= px_last_d;
    end
  end

  // NOTE: the window storage is deliberately left unreset; its contents are
  // only observed once state/pend_full mark it live, so reset discards it.
  always_ff @(posedge clk) begin
    cur_q  <= cur_d;
    pend_q <= pend_d;
  end

  assign bus.px_valid = px_valid_q;
  assign bus.px_data  = px_data_q;
  assign bus.px_first = px_first_q;
  assign bus.px_last  = px_last_q;
  assign bus.px_row   = row_q;
  assign bus.px_col   = col_q;

endmodule

// File: tb/tb_window_serializer.sv
// Self-checking bench for window_serializer: directed scenarios plus random
// traffic scored against a queue of expected beats.
module tb_window_serializer;

  localparam int W  = 12;
  localparam int WB = W * 25;

  logic clk = 1'b0;
  logic rst;
  logic en;

  window_serializer_if #(.DataBitWidth(W)) bus ();

  window_serializer #(.DataBitWidth(W)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int           r;
    int           c;
  } beat_t;

  // Expected beats of every accepted, not yet fully transferred window, in order.
  beat_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic         obs_valid, obs_first, obs_last, obs_ready;
  logic [W-1:0] obs_data;
  logic [2:0]   obs_row, obs_col;
  logic         last_acc, last_xfer;

  function automatic void push_window(input logic [WB-1:0] w);
    beat_t b;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        b.d = w[(r*5+c)*W +: W];
        b.r = r;
        b.c = c;
        exp_q.push_back(b);
      end
    end
  endfunction

  function automatic int windows_held();
    return (exp_q.size() + 24) / 25;
  endfunction

  function automatic logic [WB-1:0] make_win_rc();
    logic [WB-1:0] w;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[(r*5+c)*W +: W] = W'(r*16 + c);
    return w;
  endfunction

  function automatic logic [WB-1:0] make_win_const(input logic [W-1:0] v);
    logic [WB-1:0] w;
    for (int i = 0; i < 25; i++) w[i*W +: W] = v;
    return w;
  endfunction

  function automatic logic [WB-1:0] make_win_rand();
    logic [WB-1:0] w;
    for (int i = 0; i < 25; i++) w[i*W +: W] = W'($urandom);
    return w;
  endfunction

  // One clock cycle: drive inputs, score outputs against the model, advance the model.
  task automatic step(input logic wv, input logic [WB-1:0] wd, input logic pr, input logic e);
    logic  exp_ready, exp_valid;
    beat_t f;
    bus.win_valid = wv;
    bus.win_data  = wd;
    bus.px_ready  = pr;
    en            = e;
    #1;
    exp_valid = (exp_q.size() > 0);
    exp_ready = e && (windows_held() < 2);
    obs_valid = bus.px_valid;
    obs_first = bus.px_first;
    obs_last  = bus.px_last;
    obs_ready = bus.win_ready;
    obs_data  = bus.px_data;
    obs_row   = bus.px_row;
    obs_col   = bus.px_col;
    n_checks++;
    if (obs_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL win_ready: got %b expected %b at %0t", obs_ready, exp_ready, $time);
    end
    n_checks++;
    if (obs_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL px_valid: got %b expected %b at %0t", obs_valid, exp_valid, $time);
    end
    if (exp_valid) begin
      f = exp_q[0];
      n_checks++;
      if (obs_data !== f.d) begin
        n_fail++;
        $display("FAIL px_data: got %h expected %h at (%0d,%0d) %0t", obs_data, f.d, f.r, f.c, $time);
      end
      n_checks++;
      if (obs_row !== 3'(f.r) || obs_col !== 3'(f.c)) begin
        n_fail++;
        $display("FAIL px_row/col: got (%0d,%0d) expected (%0d,%0d) at %0t", obs_row, obs_col, f.r, f.c, $time);
      end
      n_checks++;
      if (obs_first !== (f.r == 0 && f.c == 0) || obs_last !== (f.r == 4 && f.c == 4)) begin
        n_fail++;
        $display("FAIL px_first/last: got %b/%b at (%0d,%0d) %0t", obs_first, obs_last, f.r, f.c, $time);
      end
    end
    last_acc  = wv && exp_ready;
    last_xfer = exp_valid && pr && e;
    @(posedge clk);
    if (last_xfer) void'(exp_q.pop_front());
    if (last_acc) push_window(wd);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic wait_front(input int r, input int c);
    bit found = 0;
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() > 0 && exp_q[0].r == r && exp_q[0].c == c) begin
        found = 1;
        break;
      end
      idle_step();
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_front: beat (%0d,%0d) not reached within 200 cycles", r, c);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 300) begin
      idle_step();
      k++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d beats outstanding after 300 cycles", exp_q.size());
    end
    idle_step();
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    en            = 1'b1;
    bus.win_valid = 1'b0;
    bus.win_data  = '0;
    bus.px_ready  = 1'b0;
    #3;
    n_checks++;
    if (bus.px_valid !== 1'b0 || bus.px_first !== 1'b0 || bus.px_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid/first/last %b%b%b expected 000", bus.px_valid, bus.px_first, bus.px_last);
    end
    n_checks++;
    if (bus.px_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 000", bus.px_data);
    end
    n_checks++;
    if (bus.px_row !== 3'd0 || bus.px_col !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_pos: got (%0d,%0d) expected (0,0)", bus.px_row, bus.px_col);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.win_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", bus.win_ready);
    end
  endtask

  task automatic test_single();
    int beats = 0, firsts = 0, lasts = 0, first_idx = -1, last_idx = -1;
    step(1'b1, make_win_rc(), 1'b1, 1'b1);
    n_checks++;
    if (bus.px_valid !== 1'b1 || bus.px_first !== 1'b1 || bus.px_data !== 12'h000) begin
      n_fail++;
      $display("FAIL single_latency: valid=%b first=%b data=%h expected 1 1 000", bus.px_valid, bus.px_first, bus.px_data);
    end
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      idle_step();
      if (last_xfer) begin
        if (obs_first) begin firsts++; first_idx = beats; end
        if (obs_last)  begin lasts++;  last_idx  = beats; end
        beats++;
      end
    end
    n_checks++;
    if (beats !== 25) begin
      n_fail++;
      $display("FAIL single_beats: got %0d expected 25", beats);
    end
    n_checks++;
    if (firsts !== 1 || first_idx !== 0) begin
      n_fail++;
      $display("FAIL single_first: count %0d at %0d expected 1 at 0", firsts, first_idx);
    end
    n_checks++;
    if (lasts !== 1 || last_idx !== 24) begin
      n_fail++;
      $display("FAIL single_last: count %0d at %0d expected 1 at 24", lasts, last_idx);
    end
    n_checks++;
    if (bus.px_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end_valid: got %b expected 0", bus.px_valid);
    end
    idle_step();
  endtask

  task automatic test_back_to_back();
    int run = 0, neg = 0, not_ready = 0;
    step(1'b1, make_win_const(12'h7FF), 1'b1, 1'b1);
    step(1'b1, make_win_const(12'h800), 1'b1, 1'b1);
    if (obs_valid) run++;
    n_checks++;
    if (bus.win_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_pend_ready: got %b expected 0", bus.win_ready);
    end
    for (int k = 0; k < 100; k++) begin
      idle_step();
      if (!obs_valid) break;
      run++;
      if (obs_data[W-1]) neg++;
      if (!obs_ready) not_ready++;
    end
    n_checks++;
    if (run !== 50) begin
      n_fail++;
      $display("FAIL b2b_contiguous: got %0d valid cycles expected 50", run);
    end
    n_checks++;
    if (neg !== 25) begin
      n_fail++;
      $display("FAIL b2b_sign: got %0d negative beats expected 25", neg);
    end
    n_checks++;
    if (not_ready !== 24) begin
      n_fail++;
      $display("FAIL b2b_ready_low: got %0d cycles expected 24", not_ready);
    end
  endtask

  task automatic test_stall();
    logic         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int           transfers = 0;
    logic         prev_valid = 1'b0, prev_xfer = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic [2:0]   prev_row = '0, prev_col = '0;
    step(1'b1, make_win_rand(), 1'b1, 1'b1);
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) begin
      step(1'b0, '0, pat[k % 4], 1'b1);
      if (prev_valid && !prev_xfer) begin
        n_checks++;
        if (obs_data !== prev_data || obs_row !== prev_row || obs_col !== prev_col) begin
          n_fail++;
          $display("FAIL stall_hold: got %h(%0d,%0d) expected %h(%0d,%0d)", obs_data, obs_row, obs_col, prev_data, prev_row, prev_col);
        end
      end
      if (last_xfer) transfers++;
      prev_valid = obs_valid;
      prev_xfer  = last_xfer;
      prev_data  = obs_data;
      prev_row   = obs_row;
      prev_col   = obs_col;
    end
    n_checks++;
    if (transfers !== 25) begin
      n_fail++;
      $display("FAIL stall_transfers: got %0d expected 25", transfers);
    end
    idle_step();
  endtask

  task automatic test_enable();
    logic [W-1:0] snap_data;
    logic         snap_valid;
    logic [2:0]   snap_row, snap_col;
    step(1'b1, make_win_rand(), 1'b1, 1'b1);
    wait_front(2, 3);
    snap_data  = bus.px_data;
    snap_valid = bus.px_valid;
    snap_row   = bus.px_row;
    snap_col   = bus.px_col;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, make_win_rand(), 1'b1, 1'b0);
      n_checks++;
      if (obs_data !== snap_data || obs_valid !== snap_valid || obs_row !== snap_row || obs_col !== snap_col) begin
        n_fail++;
        $display("FAIL en_freeze: got %h v%b (%0d,%0d) expected %h v%b (%0d,%0d)", obs_data, obs_valid, obs_row, obs_col, snap_data, snap_valid, snap_row, snap_col);
      end
      n_checks++;
      if (obs_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL en_ready: got %b expected 0", obs_ready);
      end
    end
    idle_step();
    n_checks++;
    if (obs_row !== 3'd2 || obs_col !== 3'd3) begin
      n_fail++;
      $display("FAIL en_resume: got (%0d,%0d) expected (2,3)", obs_row, obs_col);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int valid_after = 0;
    step(1'b1, make_win_rand(), 1'b1, 1'b1);
    step(1'b1, make_win_rand(), 1'b1, 1'b1);
    wait_front(1, 1);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.px_valid !== 1'b0 || bus.px_first !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: valid=%b first=%b expected 0 0", bus.px_valid, bus.px_first);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.win_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release_ready: got %b expected 1", bus.win_ready);
    end
    for (int k = 0; k < 30; k++) begin
      idle_step();
      if (obs_valid) valid_after++;
    end
    n_checks++;
    if (valid_after !== 0) begin
      n_fail++;
      $display("FAIL rst_residual: got %0d valid cycles expected 0", valid_after);
    end
  endtask

  task automatic test_accept_at_last();
    logic [WB-1:0] w2;
    w2 = make_win_rand();
    step(1'b1, make_win_rand(), 1'b1, 1'b1);
    wait_front(4, 4);
    step(1'b1, w2, 1'b1, 1'b1);
    n_checks++;
    if (bus.px_valid !== 1'b1 || bus.px_first !== 1'b1 || bus.px_data !== w2[W-1:0]) begin
      n_fail++;
      $display("FAIL last_accept_beat: valid=%b first=%b data=%h expected 1 1 %h", bus.px_valid, bus.px_first, bus.px_data, w2[W-1:0]);
    end
    n_checks++;
    if (bus.win_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL last_accept_pend: win_ready %b expected 1", bus.win_ready);
    end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 1)), make_win_rand(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) != 0));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_enable();
    test_reset_mid();
    test_accept_at_last();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
